stopwatch_ctrl: RTL and testbench

// - Sequencer for the 4-digit cascaded BCD stopwatch counter chain (digits d1..d4, d1 = LSD).
// - Turns start/stop, lap and clear button pulses into a count-enable tick, a chain clear and a display select.
// - Owns the tick prescaler, run/pause state, lap-freeze register and overflow (9999) stop.
// - Sits between the button debouncers and the BCD chain / 7-seg display driver.

---
 rtl/stopwatch_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 29 ++
 rtl/stopwatch_ctrl.sv | 120 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencer.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        SW_IDLE,
        SW_RUN,
        SW_PAUSE
    } sw_state_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // True when the four-digit chain shows 9999.
    function automatic logic bcd_all_max(input bcd_t a, input bcd_t b,
                                         input bcd_t c, input bcd_t e);
        return (a == BCD_MAX) && (b == BCD_MAX) && (c == BCD_MAX) && (e == BCD_MAX);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to the count rate. tick flags the wrap cycle (count == TICK_DIV-1 while
// enabled); the caller registers it into the chain enable.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    // Count only while enabled, hold otherwise; clr and reset return to zero.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: run/pause FSM, count tick generation, lap freeze, overflow stop.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic [3:0] disp1,
    output logic [3:0] disp2,
    output logic [3:0] disp3,
    output logic [3:0] disp4,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    sw_state_t   state;
    sw_state_t   state_next;
    logic [15:0] lap_reg;
    logic        wrap;
    logic        at_max;
    logic        presc_en;
    logic        presc_clr;

    assign at_max    = bcd_all_max(d1, d2, d3, d4);
    assign presc_en  = (state == SW_RUN);
    // IDLE keeps the prescaler at zero so every start begins a full period.
    assign presc_clr = (state == SW_IDLE) || ((state == SW_PAUSE) && clear);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (presc_en),
        .clr  (presc_clr),
        .tick (wrap)
    );

    // Next state with clear > start_stop priority; overflow forces PAUSE.
    always_comb begin
        state_next = state;
        unique case (state)
            SW_IDLE: begin
                if (!clear && start_stop) state_next = SW_RUN;
            end
            SW_RUN: begin
                if (start_stop || (wrap && at_max)) state_next = SW_PAUSE;
            end
            SW_PAUSE: begin
                if (clear) begin
                    state_next = SW_IDLE;
                end else if (start_stop && !overflow) begin
                    state_next = SW_RUN;
                end
            end
            default: state_next = SW_IDLE;
        endcase
    end

    // State register plus all registered outputs and the lap capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SW_IDLE;
            running    <= 1'b0;
            cnt_en     <= 1'b0;
            cnt_clr    <= 1'b0;
            lap_active <= 1'b0;
            overflow   <= 1'b0;
            lap_reg    <= '0;
        end else begin
            state   <= state_next;
            running <= (state_next == SW_RUN);
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            case (state)
                SW_IDLE: begin
                    if (clear) cnt_clr <= 1'b1;
                end
                SW_RUN: begin
                    if (wrap) begin
                        if (at_max) overflow <= 1'b1;
                        else        cnt_en   <= 1'b1;
                    end
                    // start_stop outranks lap on the same cycle.
                    if (!start_stop && lap) begin
                        lap_active <= !lap_active;
                        if (!lap_active) lap_reg <= {d4, d3, d2, d1};
                    end
                end
                SW_PAUSE: begin
                    if (clear) begin
                        cnt_clr    <= 1'b1;
                        lap_active <= 1'b0;
                        overflow   <= 1'b0;
                    end else if (!start_stop && lap) begin
                        lap_active <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Display shows the frozen lap value while lap_active, else the live chain.
    always_comb begin
        {disp4, disp3, disp2, disp1} = lap_active ? lap_reg : {d4, d3, d2, d1};
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_DIV=4 and a bench-side BCD chain.
module tb_stopwatch_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_stop = 1'b0;
    logic       lap = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
    logic       cnt_en, cnt_clr, running, lap_active, overflow;
    logic [3:0] disp1, disp2, disp3, disp4;

    int errors = 0;
    int checks = 0;

    // Chain value (0..9999) presented on d1..d4
    int chain = 0;

    // Reference model: mode 0=idle 1=run 2=pause
    int m_mode = 0;
    int m_pc = 0;
    bit m_lap = 0;
    int m_lapval = 0;
    bit m_ovf = 0;
    bit m_en = 0;
    bit m_clr = 0;

    stopwatch_ctrl #(
        .TICK_DIV(TD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_stop(start_stop),
        .lap       (lap),
        .clear     (clear),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .d4        (d4),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .disp1     (disp1),
        .disp2     (disp2),
        .disp3     (disp3),
        .disp4     (disp4),
        .running   (running),
        .lap_active(lap_active),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic drive_d();
        {d4, d3, d2, d1} = to_bcd(chain);
    endtask

    task automatic set_chain(input int v);
        chain = v;
        drive_d();
        #1;
    endtask

    // One edge of the reference model, using the pre-edge chain value.
    task automatic model_step(input bit ss, input bit lp, input bit cl, input bit rst);
        bit wrap;
        m_en  = 0;
        m_clr = 0;
        if (rst) begin
            m_mode = 0; m_pc = 0; m_lap = 0; m_lapval = 0; m_ovf = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (cl) m_clr = 1;
                    else if (ss) begin m_mode = 1; m_pc = 0; end
                end
                1: begin
                    wrap = (m_pc == TD - 1);
                    m_pc = (m_pc + 1) % TD;
                    if (ss) m_mode = 2;
                    else if (lp) begin
                        if (!m_lap) m_lapval = chain;
                        m_lap = !m_lap;
                    end
                    if (wrap) begin
                        if (chain == 9999) begin m_ovf = 1; m_mode = 2; end
                        else m_en = 1;
                    end
                end
                default: begin
                    if (cl) begin
                        m_mode = 0; m_clr = 1; m_lap = 0; m_ovf = 0; m_pc = 0;
                    end else if (ss) begin
                        if (!m_ovf) m_mode = 1;
                    end else if (lp) m_lap = 0;
                end
            endcase
        end
    endtask

    // Apply inputs for one posedge; afterwards the chain reacts to the prior tick/clear.
    task automatic cycle(input bit ss, input bit lp, input bit cl, input bit rst);
        bit pen, pclr;
        start_stop = ss; lap = lp; clear = cl; reset = rst;
        pen  = m_en;
        pclr = m_clr;
        model_step(ss, lp, cl, rst);
        @(posedge clk);
        #1;
        if (pclr) chain = 0;
        else if (pen) chain = (chain + 1) % 10000;
        drive_d();
        start_stop = 0; lap = 0; clear = 0; reset = 0;
        #1;
    endtask

    task automatic test_reset();
        cycle(0, 0, 0, 1);
        checks++;
        if ({cnt_en, cnt_clr, running, lap_active, overflow} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {cnt_en, cnt_clr, running, lap_active, overflow});
        end
        checks++;
        if ({disp4, disp3, disp2, disp1} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_disp got %h want 0000", {disp4, disp3, disp2, disp1});
        end
    endtask

    task automatic test_tick();
        cycle(0, 0, 0, 1);
        set_chain(0);
        cycle(1, 0, 0, 0);
        checks++;
        if (running !== 1'b1 || cnt_en !== 1'b0) begin
            errors++;
            $display("FAIL tick_start running/cnt_en got %b%b want 10", running, cnt_en);
        end
        for (int k = 1; k <= 12; k++) begin
            cycle(0, 0, 0, 0);
            checks++;
            if (cnt_en !== ((k % TD) == 0)) begin
                errors++;
                $display("FAIL tick_k%0d cnt_en got %b want %b", k, cnt_en, (k % TD) == 0);
            end
        end
    endtask

    task automatic test_pause_resume();
        bit seen;
        cycle(0, 0, 0, 1);
        set_chain(0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL pause_running got %b want 0", running);
        end
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(0, 0, 0, 0);
            if (cnt_en !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL pause_no_tick got cnt_en=1 want 0 while paused");
        end
        cycle(1, 0, 0, 0);
        checks++;
        if (running !== 1'b1 || cnt_en !== 1'b0) begin
            errors++;
            $display("FAIL resume running/cnt_en got %b%b want 10", running, cnt_en);
        end
        cycle(0, 0, 0, 0);
        checks++;
        if (cnt_en !== 1'b0) begin
            errors++;
            $display("FAIL resume_r1 cnt_en got %b want 0", cnt_en);
        end
        cycle(0, 0, 0, 0);
        checks++;
        if (cnt_en !== 1'b1) begin
            errors++;
            $display("FAIL resume_r2 cnt_en got %b want 1", cnt_en);
        end
    endtask

    task automatic test_lap();
        cycle(0, 0, 0, 1);
        set_chain(12);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        checks++;
        if (lap_active !== 1'b1 || {disp4, disp3, disp2, disp1} !== 16'h0012) begin
            errors++;
            $display("FAIL lap_capture got %b/%h want 1/0012",
                     lap_active, {disp4, disp3, disp2, disp1});
        end
        for (int k = 0; k < 10; k++) cycle(0, 0, 0, 0);
        checks++;
        if ({disp4, disp3, disp2, disp1} !== 16'h0012) begin
            errors++;
            $display("FAIL lap_hold disp got %h want 0012", {disp4, disp3, disp2, disp1});
        end
        cycle(0, 1, 0, 0);
        checks++;
        if (lap_active !== 1'b0 || {disp4, disp3, disp2, disp1} !== to_bcd(chain)) begin
            errors++;
            $display("FAIL lap_release got %b/%h want 0/%h",
                     lap_active, {disp4, disp3, disp2, disp1}, to_bcd(chain));
        end
    endtask

    task automatic test_overflow();
        cycle(0, 0, 0, 1);
        set_chain(9999);
        cycle(1, 0, 0, 0);
        for (int k = 1; k < TD; k++) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        checks++;
        if ({cnt_en, overflow, running} !== 3'b010) begin
            errors++;
            $display("FAIL ovf_wrap en/ovf/run got %b want 010", {cnt_en, overflow, running});
        end
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        checks++;
        if (running !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_restart run/ovf got %b%b want 01", running, overflow);
        end
        cycle(0, 0, 1, 0);
        checks++;
        if ({cnt_clr, overflow, running} !== 3'b100) begin
            errors++;
            $display("FAIL ovf_clear clr/ovf/run got %b want 100", {cnt_clr, overflow, running});
        end
        cycle(0, 0, 0, 0);
        checks++;
        if (cnt_clr !== 1'b0 || {disp4, disp3, disp2, disp1} !== 16'h0000) begin
            errors++;
            $display("FAIL ovf_clr_width clr/disp got %b/%h want 0/0000",
                     cnt_clr, {disp4, disp3, disp2, disp1});
        end
        cycle(1, 0, 0, 0);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL ovf_idle_start running got %b want 1", running);
        end
    endtask

    task automatic test_priority();
        cycle(0, 0, 0, 1);
        set_chain(50);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        checks++;
        if (running !== 1'b0 || lap_active !== 1'b1) begin
            errors++;
            $display("FAIL prio_pause run/lap got %b%b want 01", running, lap_active);
        end
        cycle(1, 1, 1, 0);
        checks++;
        if ({cnt_clr, running, lap_active, overflow} !== 4'b1000) begin
            errors++;
            $display("FAIL prio_all got %b want 1000", {cnt_clr, running, lap_active, overflow});
        end
        cycle(0, 1, 0, 0);
        checks++;
        if (lap_active !== 1'b0 || cnt_clr !== 1'b0) begin
            errors++;
            $display("FAIL prio_idle_lap lap/clr got %b%b want 00", lap_active, cnt_clr);
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        cycle(0, 0, 0, 1);
        set_chain(0);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 1, 0, 1);
        checks++;
        if ({cnt_en, cnt_clr, running, lap_active, overflow} !== 5'b0) begin
            errors++;
            $display("FAIL midrun_reset got %b want 00000",
                     {cnt_en, cnt_clr, running, lap_active, overflow});
        end
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(0, 0, 0, 0);
            if (cnt_en !== 1'b0 || running !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midrun_quiet got activity want none after reset");
        end
        cycle(1, 0, 0, 0);
        for (int k = 1; k < TD; k++) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        checks++;
        if (cnt_en !== 1'b1) begin
            errors++;
            $display("FAIL midrun_restart cnt_en got %b want 1", cnt_en);
        end
    endtask

    task automatic test_random();
        logic [20:0] got, exp;
        cycle(0, 0, 0, 1);
        set_chain(0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) set_chain(9990 + int'($urandom_range(0, 9)));
            cycle($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 6, $urandom_range(0, 199) < 1);
            got = {cnt_en, cnt_clr, running, lap_active, overflow, disp4, disp3, disp2, disp1};
            exp = {m_en, m_clr, m_mode == 1, m_lap, m_ovf, to_bcd(m_lap ? m_lapval : chain)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rand_%0d en,clr,run,lap,ovf,disp got %h want %h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_pause_resume();
        test_lap();
        test_overflow();
        test_priority();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
